// File: rtl/npu_vec_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : npu_vec_deserializer
//  Description : Packs a serial stream of signed DATA_WIDTH elements into an
//                N-element vector for the first NPU layer input. It uses a
//                valid/ready handshake on both the input and output sides.
//                It double-buffers: elements 0..N-2 of the next vector are
//                accepted while the previous vector is still held.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                s_valid/s_ready/s_data/s_last - element stream in
//                m_valid/m_ready/m_vec          - packed vector out
//                err_len        - one-cycle framing error pulse
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module npu_vec_deserializer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [N*DATA_WIDTH-1:0]   m_vec,
    output logic                      err_len
);

    localparam int             c_CW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

    logic [c_CW-1:0]                r_cnt;
    // Slots 0..N-2 only; the final element goes straight into the output.
    logic [(N-1)*DATA_WIDTH-1:0]    r_asm;
    logic [N*DATA_WIDTH-1:0]        r_vec;
    logic                           r_out_full;
    logic                           r_err;

    logic w_last_slot;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_last_slot = (r_cnt == c_LAST);

    // Only the final element needs somewhere to go; it may proceed when the
    // output register is empty or is being drained this very cycle.
    assign s_ready    = !rst && !(w_last_slot && r_out_full && !m_ready);
    assign w_in_xfer  = s_valid && s_ready;
    assign w_out_xfer = r_out_full && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_asm      <= '0;
            r_vec      <= '0;
            r_out_full <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;

            // A load below overrides this clear, keeping m_valid gap-free.
            if (w_out_xfer) begin
                r_out_full <= 1'b0;
            end

            if (w_in_xfer) begin
                if (w_last_slot) begin
                    r_vec      <= {s_data, r_asm};
                    r_out_full <= 1'b1;
                    r_cnt      <= '0;
                    r_err      <= !s_last;
                end else if (s_last) begin
                    // Early last: drop the partial vector.
                    r_cnt <= '0;
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                    for (int k = 0; k < N - 1; k++) begin
                        if (r_cnt == c_CW'(k)) begin
                            r_asm[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                        end
                    end
                end
            end
        end
    end

    assign m_valid = r_out_full;
    assign m_vec   = r_vec;
    assign err_len = r_err;

endmodule

`default_nettype wire

// File: tb/tb_npu_vec_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npu_vec_deserializer
//  Description : Self-checking bench for npu_vec_deserializer (N=4, DW=8).
//                A queue-based reference model predicts delivered vectors and
//                framing errors from the accepted element sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_vec_deserializer;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            s_last = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [N*DW-1:0] m_vec;
    logic            err_len;

    npu_vec_deserializer #(.N(N), .DATA_WIDTH(DW)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_vec   (m_vec),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0]   mdl_buf[$];
    logic [N*DW-1:0] exp_q[$];
    int              exp_err = 0;

    // Observations from the monitor
    logic [N*DW-1:0] obs_q[$];
    int              obs_err   = 0;
    int              stall_cnt = 0;
    int              stab_viol = 0;
    bit              hold_pending = 1'b0;
    logic [N*DW-1:0] held_vec = '0;
    bit              rand_mode = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) obs_q.push_back(m_vec);
            if (err_len) obs_err++;
            if (s_valid && !s_ready) stall_cnt++;
            if (hold_pending && (m_valid !== 1'b1 || m_vec !== held_vec)) stab_viol++;
            hold_pending = m_valid && !m_ready;
            held_vec     = m_vec;
        end else begin
            hold_pending = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic model_elem(input logic [DW-1:0] d, input bit last);
        logic [N*DW-1:0] v;
        mdl_buf.push_back(d);
        if (mdl_buf.size() == N) begin
            v = '0;
            for (int k = 0; k < N; k++) v[k*DW +: DW] = mdl_buf[k];
            exp_q.push_back(v);
            if (!last) exp_err++;
            mdl_buf.delete();
        end else if (last) begin
            exp_err++;
            mdl_buf.delete();
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send(input logic [DW-1:0] d, input bit last);
        bit acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) acc = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (acc) begin
            model_elem(d, last);
        end else begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: element %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_s_ready: got %b want 0", s_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid);
        end
        n_checks++;
        if (m_vec !== '0) begin
            n_fail++; $display("FAIL rst_m_vec: got %h want 0", m_vec);
        end
        n_checks++;
        if (err_len !== 1'b0) begin
            n_fail++; $display("FAIL rst_err_len: got %b want 0", err_len);
        end
        rst = 1'b0;
        mdl_buf.delete();
        exp_q.delete();
        obs_q.delete();
        exp_err   = 0;
        obs_err   = 0;
        stall_cnt = 0;
        stab_viol = 0;
    endtask

    task automatic test_basic;
        test_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_latency_valid: got %b want 1", m_valid);
        end
        n_checks++;
        if (m_vec !== 32'h04030201) begin
            n_fail++; $display("FAIL basic_vec: got %h want 04030201", m_vec);
        end
        n_checks++;
        if (err_len !== 1'b0) begin
            n_fail++; $display("FAIL basic_err: got %b want 0", err_len);
        end
        idle(4);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'h04030201) begin
            n_fail++; $display("FAIL basic_delivered: got %0d vectors want 1 (04030201)", obs_q.size());
        end
    endtask

    task automatic test_back_to_back;
        test_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
        for (int i = 1; i <= 4; i++) send(DW'(8'h80 + i), i == 4);
        idle(4);
        n_checks++;
        if (stall_cnt != 0) begin
            n_fail++; $display("FAIL b2b_stall: got %0d stall cycles want 0", stall_cnt);
        end
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d vectors want 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== 32'h04030201 || obs_q[1] !== 32'h84838281) begin
                n_fail++; $display("FAIL b2b_vecs: got %h,%h want 04030201,84838281", obs_q[0], obs_q[1]);
            end
        end
        n_checks++;
        if (obs_err != 0) begin
            n_fail++; $display("FAIL b2b_err: got %0d pulses want 0", obs_err);
        end
    endtask

    task automatic test_backpressure;
        test_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
        for (int i = 1; i <= 3; i++) send(DW'(8'h80 + i), 1'b0);
        s_valid = 1'b1; s_data = 8'h84; s_last = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_s_ready_low: got %b want 0", s_ready);
        end
        n_checks++;
        if (m_vec !== 32'h04030201 || m_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: got valid=%b vec=%h want 1/04030201", m_valid, m_vec);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_s_ready_release: got %b want 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        model_elem(8'h84, 1'b1);
        n_checks++;
        if (m_valid !== 1'b1 || m_vec !== 32'h84838281) begin
            n_fail++; $display("FAIL bp_reload: got valid=%b vec=%h want 1/84838281", m_valid, m_vec);
        end
        idle(4);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d vectors want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL bp_vec[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (stab_viol != 0) begin
            n_fail++; $display("FAIL bp_stability: got %0d violations want 0", stab_viol);
        end
    endtask

    task automatic test_early_last;
        test_reset();
        m_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        n_checks++;
        if (err_len !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL early_err: got err=%b valid=%b want 1/0", err_len, m_valid);
        end
        for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
        idle(4);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'h04030201) begin
            n_fail++; $display("FAIL early_delivered: got %0d vectors want 1 (04030201)", obs_q.size());
        end
        n_checks++;
        if (obs_err != 1) begin
            n_fail++; $display("FAIL early_err_count: got %0d pulses want 1", obs_err);
        end
    endtask

    task automatic test_missing_last;
        test_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
        n_checks++;
        if (err_len !== 1'b1 || m_valid !== 1'b1 || m_vec !== 32'h04030201) begin
            n_fail++; $display("FAIL missing_now: got err=%b valid=%b vec=%h want 1/1/04030201", err_len, m_valid, m_vec);
        end
        idle(1);
        n_checks++;
        if (err_len !== 1'b0) begin
            n_fail++; $display("FAIL missing_pulse_width: got %b want 0", err_len);
        end
        idle(3);
        n_checks++;
        if (obs_q.size() != 1 || obs_err != 1) begin
            n_fail++; $display("FAIL missing_totals: got %0d vectors %0d errs want 1/1", obs_q.size(), obs_err);
        end
    endtask

    task automatic test_reset_mid;
        test_reset();
        m_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        test_reset();
        for (int i = 1; i <= 4; i++) send(DW'(8'h40 + i), i == 4);
        idle(4);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'h44434241) begin
            n_fail++; $display("FAIL rstmid_partial: got %0d vectors want 1 (44434241)", obs_q.size());
        end
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(DW'(8'hA0 + i), i == 4);
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_held: got %b want 1", m_valid);
        end
        test_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
        idle(4);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'h04030201) begin
            n_fail++; $display("FAIL rstmid_full: got %0d vectors want 1 (04030201)", obs_q.size());
        end
    endtask

    task automatic test_random;
        int len;
        int total = 0;
        test_reset();
        rand_mode = 1'b1;
        while (total < 240) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                send(DW'($urandom), (j == len - 1) && ($urandom_range(0, 7) != 0));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            total += len;
        end
        rand_mode = 1'b0;
        idle(1);
        m_ready = 1'b1;
        idle(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d vectors want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_vec[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (obs_err != exp_err) begin
            n_fail++; $display("FAIL rand_err: got %0d pulses want %0d", obs_err, exp_err);
        end
        n_checks++;
        if (stab_viol != 0) begin
            n_fail++; $display("FAIL rand_stability: got %0d violations want 0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npu_vec_deserializer.md
# npu_vec_deserializer

Upstream feeder for the NPU datapath. Accepts a serial stream of signed `DATA_WIDTH` elements over a valid/ready handshake, packs `N` of them into a packed input vector, and presents that vector with its own valid/ready handshake to the first network layer's `in_vec`. It decouples a narrow host or DMA stream from the wide parallel layer input. It sustains one element per cycle with no bubbles between vectors.

## Interface
Parameters:
- `N`, default 4: elements per vector; must equal the first layer size (`LAYER_SIZES[0]`); N ≥ 2.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): bits per signed element.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input element valid.
- `s_ready`  out  1  block accepts the element this cycle.
- `s_data`  in  DATA_WIDTH  signed input element.
- `s_last`  in  1  marks the final element of a vector.
- `m_valid`  out  1  packed vector valid.
- `m_ready`  in  1  downstream accepts the vector this cycle.
- `m_vec`  out  N*DATA_WIDTH  packed signed vector; element k is at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `err_len`  out  1  one-cycle pulse on a framing error.

## Operation
- A transfer occurs when `s_valid && s_ready` (input side) or `m_valid && m_ready` (output side).
- State: `cnt` (0..N-1, index of the next element), an assembly register of N elements, an output register, and an `out_full` flag (drives `m_valid`).
- Input transfer with `cnt < N-1` and `s_last = 0`: write `s_data` to slot `cnt`, then `cnt++`.
- Input transfer with `cnt = N-1`: write slot N-1 and move the complete vector into the output register. Set `out_full`, set `cnt` to 0. If `s_last = 0`, pulse `err_len`; the vector is still delivered.
- Input transfer with `s_last = 1` and `cnt < N-1` (early last): discard the partial vector, set `cnt` to 0, pulse `err_len`. Nothing is delivered.
- Output transfer: clear `out_full` unless a new vector is loaded in the same cycle. In that case `out_full` stays 1 and `m_vec` takes the new vector.
- Backpressure: `s_ready = !rst && !(cnt == N-1 && out_full && !m_ready)`. Elements 0..N-2 are always accepted, even while a vector is held, so the block double-buffers.
- Elements are stored bit-exact, with no sign extension or saturation.
- Unwritten slots are don't-care internally. `m_vec` only changes on a load.

## Timing
- Reset (`rst` high at a clock edge): `cnt`=0, `out_full`=0, `m_valid`=0, `m_vec`=0, `err_len`=0. `s_ready`=0 while `rst` is high.
- Reset mid-vector drops any partial vector and any held, unconsumed vector. There is no output transfer in a reset cycle.
- Latency: if the last element is accepted at edge t, `m_valid`=1 and `m_vec` is valid after edge t (observable in cycle t+1).
- Throughput: N accepted elements per vector, back-to-back, with `s_ready` held high, provided `m_ready` is high when each vector completes.
- `s_ready` depends combinationally on `m_ready`. `m_valid`, `m_vec` and `err_len` are registered.
- `m_valid`, once high, stays high with `m_vec` stable until an output transfer occurs.
- `err_len` is high for exactly one cycle after the offending input transfer.
- Simultaneous final input transfer and output transfer: the old vector is consumed, the new vector loads, and `m_valid` stays 1 with no gap.

## Test plan
- N=4, DW=8. Stream 0x01,0x02,0x03,0x04 (last on 0x04), with `m_ready`=1 → one cycle later `m_valid`=1, `m_vec`=0x04030201, `err_len`=0.
- Two back-to-back vectors (0x01..0x04, then 0x81..0x84) with `m_ready`=1 → `s_ready` is never low; `m_vec`=0x04030201 and then 0x84838281 on consecutive vector boundaries.
- Hold `m_ready`=0 after the first vector, then stream the second → elements 0x81..0x83 are accepted; `s_ready` drops at `cnt`=3. When `m_ready` rises, 0x04030201 is consumed and 0x84 is accepted the same cycle; `m_vec`=0x84838281 the next cycle.
- Early last: 0x11, 0x22(last), then 0x01..0x04(last) → `err_len` pulses once after 0x22; the only vector delivered is 0x04030201.
- Missing last: 0x01..0x04 with `s_last`=0 throughout → `m_vec`=0x04030201 is delivered and `err_len` pulses once.
- Assert `rst` after 2 elements, and separately while `m_valid`=1 → all outputs return to 0. The next full 4-element stream delivers only that stream's vector.
